// File: rtl/lvds_tx_unpacker_pkg.sv
// Shared definitions for the LVDS transmit unpacker and future BE-aware blocks.
//   LVDS_LEN / DATA_LEN / BE_LEN : default bus widths
//   state_e                      : IDLE/SHIFT encoding of the shift stage
//   lowest_set()                 : lowest-set-bit priority select (index + one-hot)
package lvds_tx_unpacker_pkg;

  localparam int unsigned LVDS_LEN = 8;
  localparam int unsigned BE_LEN   = 4;
  localparam int unsigned DATA_LEN = LVDS_LEN * BE_LEN;
  localparam int unsigned BE_IDX_W = $clog2(BE_LEN);

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  typedef struct packed {
    logic [BE_IDX_W-1:0] idx;
    logic [BE_LEN-1:0]   onehot;
  } lsb_sel_t;

  // Lowest set bit of mask; all-zero result when mask is empty.
  function automatic lsb_sel_t lowest_set(input logic [BE_LEN-1:0] mask);
    lsb_sel_t sel;
    sel = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = BE_LEN - 1; i >= 0; i--) begin
      if (mask[i]) begin
        sel.idx       = BE_IDX_W'(i);
        sel.onehot    = '0;
        sel.onehot[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/lvds_tx_unpacker_word_fifo2.sv
// word_fifo2: 2-entry synchronous FIFO holding {data, be} words.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   push_i, data_i,
//   be_i              : write side; push ignored when full unless popping too
//   pop_i             : drop head; ignored when empty
//   data_o, be_o      : head entry (valid when !empty_o)
//   count_o           : occupancy 0..2
//   full_o, empty_o   : occupancy flags
module word_fifo2
  import lvds_tx_unpacker_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [DATA_LEN-1:0] data_i,
  input  logic [BE_LEN-1:0]   be_i,
  input  logic                pop_i,
  output logic [DATA_LEN-1:0] data_o,
  output logic [BE_LEN-1:0]   be_o,
  output logic [1:0]          count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [DATA_LEN-1:0] mem_data_q [2];
  logic [BE_LEN-1:0]   mem_be_q   [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic                push_ok;
  logic                pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign pop_ok  = pop_i && !empty_o;
  // Head is read combinationally, so writing the slot being popped is safe.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_data_q[wr_ptr_q] <= data_i;
        mem_be_q[wr_ptr_q]   <= be_i;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign data_o  = mem_data_q[rd_ptr_q];
  assign be_o    = mem_be_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/lvds_tx_unpacker.sv
// lvds_tx_unpacker: emits the enabled bytes of 32-bit words one per clock, LSB first.
//   clk, rst_n  : clock, synchronous active-low reset
//   valid_i     : input word valid; accepted when valid_i && ready_o
//   data_i      : input word, byte k at [8k+7:8k]
//   be_i        : byte enables; all-zero words are accepted and discarded
//   ready_o     : registered, buffer has room after this edge
//   data_o      : registered output byte, holds when idle
//   strob_o     : registered, data_o valid
//   busy_o      : buffer non-empty or current word still has bytes to send
module lvds_tx_unpacker #(
  parameter int unsigned LVDS_LEN = lvds_tx_unpacker_pkg::LVDS_LEN,
  parameter int unsigned DATA_LEN = lvds_tx_unpacker_pkg::DATA_LEN,
  parameter int unsigned BE_LEN   = lvds_tx_unpacker_pkg::BE_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic [DATA_LEN-1:0] data_i,
  input  logic [BE_LEN-1:0]   be_i,
  output logic                ready_o,
  output logic [LVDS_LEN-1:0] data_o,
  output logic                strob_o,
  output logic                busy_o
);

  import lvds_tx_unpacker_pkg::*;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                strob_q, strob_d;
  logic [LVDS_LEN-1:0] data_q, data_d;
  logic [DATA_LEN-1:0] cur_data_q, cur_data_d;
  logic [BE_LEN-1:0]   remain_q, remain_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic [DATA_LEN-1:0] head_data;
  logic [BE_LEN-1:0]   head_be;
  logic [1:0]          fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  logic                src_valid;
  logic [DATA_LEN-1:0] src_data;
  logic [BE_LEN-1:0]   src_be;
  lsb_sel_t            sel;
  logic [1:0]          count_next;

  word_fifo2 u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .data_i  (data_i),
    .be_i    (be_i),
    .pop_i   (fifo_pop),
    .data_o  (head_data),
    .be_o    (head_be),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Source selection: finish the current word first, then pull the buffer head.
  always_comb begin
    fifo_pop  = 1'b0;
    src_valid = 1'b0;
    src_data  = cur_data_q;
    src_be    = remain_q;
    if (state_q == StShift && remain_q != '0) begin
      src_valid = 1'b1;
    end else if (!fifo_empty) begin
      src_valid = 1'b1;
      src_data  = head_data;
      src_be    = head_be;
      fifo_pop  = 1'b1;
    end
  end

  // Zero-BE words are acknowledged by ready_o but never enter the buffer.
  assign fifo_push = valid_i && ready_q && (be_i != '0) && (!fifo_full || fifo_pop);

  always_comb begin
    sel        = lowest_set(src_be);
    strob_d    = src_valid;
    data_d     = data_q;
    remain_d   = remain_q;
    cur_data_d = cur_data_q;
    if (src_valid) begin
      data_d     = src_data[LVDS_LEN * 32'(sel.idx) +: LVDS_LEN];
      remain_d   = src_be & ~sel.onehot;
      cur_data_d = src_data;
    end

    count_next = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
    ready_d    = (count_next < 2'd2);

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fifo_push) state_d = StShift;
      StShift: if (remain_d == '0 && count_next == 2'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      strob_q    <= 1'b0;
      data_q     <= '0;
      cur_data_q <= '0;
      remain_q   <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      strob_q    <= strob_d;
      data_q     <= data_d;
      cur_data_q <= cur_data_d;
      remain_q   <= remain_d;
    end
  end

  assign ready_o = ready_q;
  assign strob_o = strob_q;
  assign data_o  = data_q;
  assign busy_o  = (fifo_count != 2'd0) || (remain_q != '0);

endmodule

// File: tb/tb_lvds_tx_unpacker.sv
// Self-checking bench for lvds_tx_unpacker: directed cases, random sparse-BE
// traffic and a byte-to-word loopback, all against a byte/word scoreboard.
module tb_lvds_tx_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [3:0]  be_i = '0;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        strob_o;
  logic        busy_o;

  always #5 clk = ~clk;

  lvds_tx_unpacker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .data_i  (data_i),
    .be_i    (be_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .strob_o (strob_o),
    .busy_o  (busy_o)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] lb_q[$];
  bit          lb_en = 1'b0;
  logic [31:0] lb_acc = '0;
  int          lb_n = 0;
  int          run_len = 0;
  int          last_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobed byte must be the next expected byte; in loopback mode
  // bytes are also reassembled LSB-first into words.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      lb_n    = 0;
    end else if (strob_o) begin
      run_len++;
      if (exp_q.size() == 0) chk("byte_expected", 32'(exp_q.size()), 32'd1);
      else chk("byte", {24'b0, data_o}, {24'b0, exp_q.pop_front()});
      if (lb_en) begin
        lb_acc[8*lb_n +: 8] = data_o;
        lb_n++;
        if (lb_n == 4) begin
          lb_n = 0;
          if (lb_q.size() == 0) chk("lb_word_expected", 32'(lb_q.size()), 32'd1);
          else chk("loopback_word", lb_acc, lb_q.pop_front());
        end
      end
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  // Present a word from a negedge and hold it until accepted; returns the number
  // of cycles ready_o was low. valid_i drops just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] be, output int waits);
    waits = 0;
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = d;
    be_i    = be;
    while (!ready_o && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!ready_o) begin
      chk("send_timeout", 32'(waits), 32'd0);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (be[k]) exp_q.push_back(d[8*k +: 8]);
    if (lb_en) lb_q.push_back(d);
    #1 valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    @(negedge clk);
    while (busy_o && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_busy"}, {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    chk({name, "_strob"}, {31'b0, strob_o}, 32'd0);
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_strob", {31'b0, strob_o}, 32'd0);
    chk("rst_data", {24'b0, data_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, ready_o}, 32'd1);

    // Single word: one cycle of latency, then four strobed bytes
    send(32'hDDCCBBAA, 4'hF, w);
    @(negedge clk);
    chk("lat_no_strobe", {31'b0, strob_o}, 32'd0);
    chk("lat_busy", {31'b0, busy_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single_strobe", {31'b0, strob_o}, 32'd1);
    end
    chk("single_busy_end", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    chk("single_idle", {31'b0, strob_o}, 32'd0);

    // Back-to-back: 12 contiguous bytes
    send(32'h03020100, 4'hF, w);
    send(32'h07060504, 4'hF, w);
    send(32'h0B0A0908, 4'hF, w);
    @(negedge clk);
    chk("b2b_full_ready", {31'b0, ready_o}, 32'd0);
    wait_drain("b2b");
    @(negedge clk);
    chk("b2b_run", 32'(last_run), 32'd12);

    // Full buffer: fourth word waits until the second word is popped
    send(32'h13121110, 4'hF, w);
    send(32'h17161514, 4'hF, w);
    send(32'h1B1A1918, 4'hF, w);
    send(32'h1F1E1D1C, 4'hF, w);
    chk("full_wait_cycles", 32'(w), 32'd3);
    wait_drain("full");
    @(negedge clk);
    chk("full_run", 32'(last_run), 32'd16);

    // Sparse and zero byte enables
    send(32'h44332211, 4'b1010, w);
    send(32'h55667788, 4'b0000, w);
    chk("zero_be_accepted", 32'(w), 32'd0);
    send(32'h000000EE, 4'b0001, w);
    wait_drain("sparse");

    // Reset after two bytes of a word
    send(32'hA4A3A2A1, 4'hF, w);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_strob", {31'b0, strob_o}, 32'd0);
    chk("midrst_busy", {31'b0, busy_o}, 32'd0);
    chk("midrst_ready", {31'b0, ready_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", {31'b0, ready_o}, 32'd1);
    send(32'hC4C3C2C1, 4'hF, w);
    wait_drain("midrst_new");

    // Random sparse traffic with random gaps
    for (int i = 0; i < 40; i++) begin
      send($urandom, 4'($urandom_range(0, 15)), w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("rand");

    // Loopback through a byte-to-word packer model
    lb_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send($urandom, 4'hF, w);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    wait_drain("lb");
    chk("lb_words_left", 32'(lb_q.size()), 32'd0);
    chk("lb_partial", 32'(lb_n), 32'd0);
    lb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lvds_tx_unpacker.md
# lvds_tx_unpacker

Transmit-side LVDS byte unpacker. It accepts 32-bit words with byte enables, typically host data read from the FT601 through the FSM's `rx_data`/`rx_be` path. It emits the enabled bytes one per clock on an 8-bit LVDS data bus with a strobe. It is the reverse of the `packer8to32` receive path and lets the FPGA drive stimulus onto the LVDS link at one byte per cycle.

## Interface
Parameters:
- `LVDS_LEN`, 8, output byte width
- `DATA_LEN`, 32, input word width; equals `LVDS_LEN*BE_LEN`
- `BE_LEN`, 4, byte-enable width

Ports:
- `clk`  in  1  single clock for the block; all logic on its rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `valid_i`  in  1  input word valid
- `data_i`  in  DATA_LEN  input word; byte k = `data_i[8k+7:8k]`
- `be_i`  in  BE_LEN  byte enables; bit k qualifies byte k
- `ready_o`  out  1  registered; word accepted on an edge where `valid_i && ready_o`
- `data_o`  out  LVDS_LEN  registered output byte
- `strob_o`  out  1  registered; `data_o` valid
- `busy_o`  out  1  buffer non-empty or current word has bytes remaining

## Operation
- 2-entry word buffer (`data`, `be`) feeds a shift stage that holds `cur_data` and a `remain` mask.
- Accept: on `valid_i && ready_o`, push `{data_i, be_i}`. If `be_i == 0`, the word is accepted and discarded: no push, no output.
- Source selection each cycle:
  - If `remain != 0`, use `cur`.
  - Else, if the buffer is non-empty, use the buffer head and pop it on this edge.
  - Else, go idle.
- On each edge with a source:
  - `data_o` ← byte at the lowest set bit of the source mask.
  - `strob_o` ← 1.
  - `remain` ← source mask with that bit cleared.
  - `cur_data` ← source data.
- Byte order is ascending byte index (LSB first). This matches `packer8to32`, so a loopback reproduces the word.
- Sparse BE: only enabled bytes are sent, still in ascending order. For example, BE=4'b1010 sends byte1 then byte3.
- No source: `strob_o` ← 0; `data_o` holds its last value.
- States:
  - IDLE: `remain == 0` and buffer empty.
  - SHIFT: otherwise.
  - IDLE→SHIFT on a buffer push. SHIFT→IDLE when the last enabled byte leaves and the buffer is empty.
- `ready_o` ← (buffer count after this edge's push/pop) < 2.
- `busy_o` = (count != 0) || (remain != 0); combinational.

## Timing
- Reset (`rst_n` low at an edge):
  - Outputs: `ready_o`=0, `strob_o`=0, `data_o`=0, `busy_o`=0.
  - Internal: count=0, `remain`=0.
  - `ready_o` rises at the first edge with `rst_n` high.
- Latency: word accepted at edge N while idle → first byte has `strob_o`=1 after edge N+1.
- Streaming: the next word's first byte follows the previous word's last byte on the very next cycle. There is no gap while the buffer is non-empty.
- Throughput: 1 byte/clk. A 4-byte word occupies 4 cycles on the output.
- Full buffer: `ready_o`=0. If an edge pops while full, `ready_o` returns to 1 after that edge. Push and pop on the same edge leave count unchanged.
- Pointer wrap: the 1-bit read and write pointers wrap freely; count (0..2) disambiguates full from empty.
- Reset mid-word: remaining bytes and buffered words are dropped. `strob_o` is 0 after the reset edge.
- `valid_i` while `ready_o`=0: ignored. The source must hold the word; this is AXI-style, and no drop counter exists.

## Structure
- Shared package: `LVDS_LEN`, `DATA_LEN`, `BE_LEN`, the IDLE/SHIFT encoding, and a lowest-set-bit priority function (index + one-hot) reused by future BE-aware blocks.
- One sub-module: `word_fifo2`, a 2-entry synchronous FIFO with push, pop, count, `data`/`be` outputs and `full`/`empty`.
- The top holds the shift stage, the output registers and the ready logic.

## Test plan
- Reset then 1 word: data_i=32'hDDCCBBAA, BE=4'hF → after N+1, strob_o high for 4 cycles with data_o AA, BB, CC, DD; then strob_o=0 and busy_o=0.
- Back-to-back: 3 words 32'h03020100, 32'h07060504, 32'h0B0A0908 with valid held → 12 contiguous strobed bytes 00..0B. ready_o deasserts when the buffer fills and valid is held until accepted.
- Sparse/zero BE: 32'h44332211 BE=4'b1010 → bytes 22, 44; then BE=0 word → accepted, no strobe; then 32'h000000EE BE=4'b0001 → EE.
- Full buffer: hold output busy with 4-byte words, present a 4th word → ready_o=0 until the first pop, and no word is lost or duplicated. Compare against a scoreboard.
- Reset mid-word: assert rst_n=0 after 2 bytes of a 4-byte word → strob_o=0, busy_o=0, ready_o=0 next cycle; after release, a new word streams correctly.
- Loopback: drive data_o/strob_o into `packer8to32` with random full-BE words → the packer reproduces every word in order.
